// File: rtl/spawn_scheduler.sv
// Spawn scheduler: arbitrates army/enemy spawn requests onto the shared stats/pixel ROM port,
// allocates the lowest free battle slot and tracks per-army-type deploy cooldowns.
module spawn_scheduler #(
  parameter int unsigned ARMY_SLOTS  = 8,
  parameter int unsigned ENEMY_SLOTS = 8,
  parameter logic [15:0] COOLDOWN    = 16'd600
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic                   army_req_i,
  input  logic [2:0]             army_type_i,
  output logic                   army_ack_o,
  output logic                   army_nack_o,
  input  logic                   enemy_req_i,
  input  logic [1:0]             enemy_type_i,
  output logic                   enemy_ack_o,
  output logic                   enemy_nack_o,
  output logic                   rom_sel_o,
  output logic [2:0]             rom_addr_o,
  input  logic [37:0]            rom_stats_i,
  input  logic [18:0]            rom_pixel_i,
  output logic                   wr_en_o,
  output logic                   wr_side_o,
  output logic [2:0]             wr_slot_o,
  output logic [37:0]            wr_stats_o,
  output logic [18:0]            wr_pixel_o,
  input  logic                   free_vld_i,
  input  logic                   free_side_i,
  input  logic [2:0]             free_idx_i,
  output logic [ARMY_SLOTS-1:0]  army_busy_o,
  output logic [ENEMY_SLOTS-1:0] enemy_busy_o,
  output logic [7:0]             cd_busy_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_e;

  state_e                 state_q, state_d;
  logic                   side_q, side_d;
  logic [2:0]             type_q, type_d;
  logic [2:0]             slot_q, slot_d;
  logic                   rr_q, rr_d;  // 0: army has priority, 1: enemy
  logic [37:0]            stats_q, stats_d;
  logic [18:0]            pixel_q, pixel_d;
  logic [ARMY_SLOTS-1:0]  army_busy_q, army_busy_d;
  logic [ENEMY_SLOTS-1:0] enemy_busy_q, enemy_busy_d;
  logic [15:0]            cd_q [8];
  logic [15:0]            cd_d [8];

  logic       is_idle, is_fetch, is_write;
  logic       army_free_any, enemy_free_any;
  logic [2:0] army_free_idx, enemy_free_idx;
  logic       army_elig, enemy_elig, grant_army, grant_enemy;
  logic       free_reserved;

  assign is_idle  = (state_q == StIdle);
  assign is_fetch = (state_q == StFetch);
  assign is_write = (state_q == StWrite);

  // Lowest-index free slot per side.
  always_comb begin
    army_free_any  = 1'b0;
    army_free_idx  = 3'd0;
    enemy_free_any = 1'b0;
    enemy_free_idx = 3'd0;
    for (int i = ARMY_SLOTS - 1; i >= 0; i--) begin
      if (!army_busy_q[i]) begin
        army_free_any = 1'b1;
        army_free_idx = 3'(i);
      end
    end
    for (int i = ENEMY_SLOTS - 1; i >= 0; i--) begin
      if (!enemy_busy_q[i]) begin
        enemy_free_any = 1'b1;
        enemy_free_idx = 3'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cd_busy_o[i] = (cd_q[i] != 16'd0);
    end
  end

  assign army_elig    = is_idle & army_req_i & ~cd_busy_o[army_type_i] & army_free_any;
  assign enemy_elig   = is_idle & enemy_req_i & enemy_free_any;
  assign army_nack_o  = is_idle & army_req_i & ~army_elig;
  assign enemy_nack_o = is_idle & enemy_req_i & ~enemy_elig;
  assign grant_army   = army_elig & (~enemy_elig | ~rr_q);
  assign grant_enemy  = enemy_elig & ~grant_army;

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    type_d  = type_q;
    slot_d  = slot_q;
    rr_d    = rr_q;
    stats_d = stats_q;
    pixel_d = pixel_q;
    unique case (state_q)
      StIdle: begin
        if (grant_army || grant_enemy) begin
          state_d = StFetch;
          side_d  = grant_enemy;
          type_d  = grant_enemy ? {1'b0, enemy_type_i} : army_type_i;
          slot_d  = grant_enemy ? enemy_free_idx : army_free_idx;
          rr_d    = grant_army;
        end
      end
      StFetch: begin
        state_d = StWrite;
        stats_d = rom_stats_i;
        pixel_d = rom_pixel_i;
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The slot latched for the in-flight spawn cannot be released until it is written.
  assign free_reserved = ~is_idle & (free_side_i == side_q) & (free_idx_i == slot_q);

  always_comb begin
    army_busy_d  = army_busy_q;
    enemy_busy_d = enemy_busy_q;
    for (int i = 0; i < ARMY_SLOTS; i++) begin
      if (free_vld_i && !free_side_i && !free_reserved && free_idx_i == 3'(i)) begin
        army_busy_d[i] = 1'b0;
      end
      if (is_write && !side_q && slot_q == 3'(i)) army_busy_d[i] = 1'b1;
    end
    for (int i = 0; i < ENEMY_SLOTS; i++) begin
      if (free_vld_i && free_side_i && !free_reserved && free_idx_i == 3'(i)) begin
        enemy_busy_d[i] = 1'b0;
      end
      if (is_write && side_q && slot_q == 3'(i)) enemy_busy_d[i] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cd_d[i] = cd_q[i];
      if (tick_i && cd_q[i] != 16'd0) cd_d[i] = cd_q[i] - 16'd1;
      if (is_write && !side_q && type_q == 3'(i)) cd_d[i] = COOLDOWN;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      side_q       <= 1'b0;
      type_q       <= 3'd0;
      slot_q       <= 3'd0;
      rr_q         <= 1'b0;
      stats_q      <= 38'd0;
      pixel_q      <= 19'd0;
      army_busy_q  <= '0;
      enemy_busy_q <= '0;
      for (int i = 0; i < 8; i++) cd_q[i] <= 16'd0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      type_q       <= type_d;
      slot_q       <= slot_d;
      rr_q         <= rr_d;
      stats_q      <= stats_d;
      pixel_q      <= pixel_d;
      army_busy_q  <= army_busy_d;
      enemy_busy_q <= enemy_busy_d;
      for (int i = 0; i < 8; i++) cd_q[i] <= cd_d[i];
    end
  end

  assign rom_sel_o    = is_fetch & side_q;
  assign rom_addr_o   = is_fetch ? type_q : 3'd0;
  assign wr_en_o      = is_write;
  assign wr_side_o    = is_write & side_q;
  assign wr_slot_o    = is_write ? slot_q : 3'd0;
  assign wr_stats_o   = is_write ? stats_q : 38'd0;
  assign wr_pixel_o   = is_write ? pixel_q : 19'd0;
  assign army_ack_o   = is_write & ~side_q;
  assign enemy_ack_o  = is_write & side_q;
  assign army_busy_o  = army_busy_q;
  assign enemy_busy_o = enemy_busy_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler: directed spawns push expected events, a negedge
// monitor pops and compares every ack/nack/write the DUT presents.
module tb_spawn_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        army_req = 1'b0;
  logic [2:0]  army_type = 3'd0;
  logic        army_ack, army_nack;
  logic        enemy_req = 1'b0;
  logic [1:0]  enemy_type = 2'd0;
  logic        enemy_ack, enemy_nack;
  logic        rom_sel;
  logic [2:0]  rom_addr;
  logic [37:0] rom_stats;
  logic [18:0] rom_pixel;
  logic        wr_en, wr_side;
  logic [2:0]  wr_slot;
  logic [37:0] wr_stats;
  logic [18:0] wr_pixel;
  logic        free_vld = 1'b0;
  logic        free_side = 1'b0;
  logic [2:0]  free_idx = 3'd0;
  logic [7:0]  army_busy, enemy_busy, cd_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int army_ack_cyc = 0;
  int enemy_ack_cyc = 0;

  typedef struct {
    bit          nack;
    bit          side;
    logic [2:0]  slot;
    logic [37:0] stats;
    logic [18:0] pixel;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  spawn_scheduler dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tick_i       (tick),
    .army_req_i   (army_req),
    .army_type_i  (army_type),
    .army_ack_o   (army_ack),
    .army_nack_o  (army_nack),
    .enemy_req_i  (enemy_req),
    .enemy_type_i (enemy_type),
    .enemy_ack_o  (enemy_ack),
    .enemy_nack_o (enemy_nack),
    .rom_sel_o    (rom_sel),
    .rom_addr_o   (rom_addr),
    .rom_stats_i  (rom_stats),
    .rom_pixel_i  (rom_pixel),
    .wr_en_o      (wr_en),
    .wr_side_o    (wr_side),
    .wr_slot_o    (wr_slot),
    .wr_stats_o   (wr_stats),
    .wr_pixel_o   (wr_pixel),
    .free_vld_i   (free_vld),
    .free_side_i  (free_side),
    .free_idx_i   (free_idx),
    .army_busy_o  (army_busy),
    .enemy_busy_o (enemy_busy),
    .cd_busy_o    (cd_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [37:0] rom_s(input logic sel, input logic [2:0] a);
    return {sel, a, 2'b10, a, 29'h0ABCDE0 + 29'({sel, a})};
  endfunction

  function automatic logic [18:0] rom_p(input logic sel, input logic [2:0] a);
    return {a, sel, 15'h1234 ^ 15'({a, sel, a})};
  endfunction

  assign rom_stats = rom_s(rom_sel, rom_addr);
  assign rom_pixel = rom_p(rom_sel, rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ack(input bit side, input logic [2:0] slot, input logic [2:0] typ);
    exp_t e;
    e.nack  = 1'b0;
    e.side  = side;
    e.slot  = slot;
    e.stats = rom_s(side, typ);
    e.pixel = rom_p(side, typ);
    sb.push_back(e);
  endtask

  task automatic push_nack(input bit side);
    exp_t e;
    e.nack  = 1'b1;
    e.side  = side;
    e.slot  = 3'd0;
    e.stats = 38'd0;
    e.pixel = 19'd0;
    sb.push_back(e);
  endtask

  // Raise a request, hold it until ack/nack, drop it the following cycle.
  task automatic do_req(input bit side, input logic [2:0] typ);
    bit done = 1'b0;
    int n = 0;
    @(posedge clk);
    #1;
    if (side) begin
      enemy_req  = 1'b1;
      enemy_type = typ[1:0];
    end else begin
      army_req  = 1'b1;
      army_type = typ;
    end
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (side ? (enemy_ack | enemy_nack) : (army_ack | army_nack)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: side %0d got no ack/nack, expected one within 20 cycles", side);
    end
    @(posedge clk);
    #1;
    if (side) enemy_req = 1'b0;
    else army_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    army_req = 1'b0;
    enemy_req = 1'b0;
    tick = 1'b0;
    free_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_free(input bit side, input logic [2:0] idx);
    @(posedge clk);
    #1;
    free_vld = 1'b1;
    free_side = side;
    free_idx = idx;
    @(posedge clk);
    #1 free_vld = 1'b0;
  endtask

  // Monitor: every DUT event is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en || army_ack || enemy_ack) begin
        chk("ack_strobes", {61'd0, wr_en, army_ack, enemy_ack}, {61'd0, 1'b1, ~wr_side, wr_side});
        if (army_ack) army_ack_cyc = cyc;
        if (enemy_ack) enemy_ack_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write side %0d slot %0d, expected none",
                   wr_side, wr_slot);
        end else begin
          mon_e = sb.pop_front();
          chk("evt_is_nack", 64'(1'b0), 64'(mon_e.nack));
          chk("wr_side", 64'(wr_side), 64'(mon_e.side));
          chk("wr_slot", 64'(wr_slot), 64'(mon_e.slot));
          chk("wr_stats", 64'(wr_stats), 64'(mon_e.stats));
          chk("wr_pixel", 64'(wr_pixel), 64'(mon_e.pixel));
        end
      end
      if (army_nack || enemy_nack) begin
        for (int s = 0; s < 2; s++) begin
          if ((s == 0) ? army_nack : enemy_nack) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_nack: got nack side %0d, expected none", s);
            end else begin
              mon_e = sb.pop_front();
              chk("evt_is_nack", 64'(1'b1), 64'(mon_e.nack));
              chk("nack_side", 64'(s), 64'(mon_e.side));
            end
          end
        end
      end
    end
  end

  initial begin
    int seen_wr;
    do_reset();

    // Reset state.
    chk("rst_army_busy", 64'(army_busy), 64'h00);
    chk("rst_enemy_busy", 64'(enemy_busy), 64'h00);
    chk("rst_cd_busy", 64'(cd_busy), 64'h00);
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_rom_addr", 64'({rom_sel, rom_addr}), 64'h0);
    chk("rst_acks", 64'({army_ack, army_nack, enemy_ack, enemy_nack}), 64'h0);

    // Simultaneous requests: army first after reset, enemy three cycles later.
    push_ack(1'b0, 3'd0, 3'd1);
    push_ack(1'b1, 3'd0, 3'd2);
    fork
      do_req(1'b0, 3'd1);
      do_req(1'b1, 3'd2);
    join
    chk("pair_ack_gap", 64'(enemy_ack_cyc - army_ack_cyc), 64'd3);
    // Lone army grant leaves priority with the enemy, so the next pair goes enemy first.
    push_ack(1'b0, 3'd1, 3'd4);
    do_req(1'b0, 3'd4);
    push_ack(1'b1, 3'd1, 3'd0);
    push_ack(1'b0, 3'd2, 3'd5);
    fork
      do_req(1'b0, 3'd5);
      do_req(1'b1, 3'd0);
    join
    chk("pair2_ack_gap", 64'(army_ack_cyc - enemy_ack_cyc), 64'd3);
    chk("pair_army_busy", 64'(army_busy), 64'h07);
    chk("pair_enemy_busy", 64'(enemy_busy), 64'h03);

    // Cooldown on army type 3.
    do_reset();
    push_ack(1'b0, 3'd0, 3'd3);
    do_req(1'b0, 3'd3);
    chk("cd_after_spawn", 64'(cd_busy), 64'h08);
    chk("army_busy_1", 64'(army_busy), 64'h01);
    push_nack(1'b0);
    do_req(1'b0, 3'd3);
    @(posedge clk);
    #1 tick = 1'b1;
    repeat (599) @(posedge clk);
    #1 tick = 1'b0;
    chk("cd_599_ticks", 64'(cd_busy), 64'h08);
    @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    chk("cd_600_ticks", 64'(cd_busy), 64'h00);
    push_ack(1'b0, 3'd1, 3'd3);
    do_req(1'b0, 3'd3);
    chk("army_busy_2", 64'(army_busy), 64'h03);

    // Fill the enemy table, overflow, then release and reuse slot 5.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_ack(1'b1, 3'(i), 3'(i % 4));
      do_req(1'b1, 3'(i % 4));
    end
    chk("enemy_full", 64'(enemy_busy), 64'hFF);
    push_nack(1'b1);
    do_req(1'b1, 3'd0);
    pulse_free(1'b1, 3'd5);
    chk("enemy_free5", 64'(enemy_busy), 64'hDF);
    push_ack(1'b1, 3'd5, 3'd2);
    do_req(1'b1, 3'd2);
    chk("enemy_refill", 64'(enemy_busy), 64'hFF);

    // Release of the reserved slot is ignored; another release lands with the write.
    pulse_free(1'b1, 3'd2);
    chk("enemy_free2", 64'(enemy_busy), 64'hFB);
    push_ack(1'b1, 3'd2, 3'd3);
    fork
      do_req(1'b1, 3'd3);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rom_sel && n < 20);
        chk("fetch_seen", 64'(rom_sel), 64'h1);
        free_vld = 1'b1;
        free_side = 1'b1;
        free_idx = 3'd2;
        @(negedge clk);
        free_idx = 3'd6;
        @(negedge clk);
        free_vld = 1'b0;
      end
    join
    chk("same_edge_busy", 64'(enemy_busy), 64'hBF);

    // Reset during FETCH aborts the spawn.
    do_reset();
    @(posedge clk);
    #1;
    army_req = 1'b1;
    army_type = 3'd6;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rom_addr != 3'd6 && n < 20);
    end
    chk("abort_in_fetch", 64'(rom_addr), 64'h6);
    rst = 1'b1;
    army_req = 1'b0;
    #1;
    chk("abort_rom_addr", 64'({rom_sel, rom_addr}), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen_wr = 0;
    repeat (4) begin
      @(negedge clk);
      if (wr_en || army_ack) seen_wr++;
    end
    chk("abort_no_write", 64'(seen_wr), 64'd0);
    chk("abort_busy", 64'({army_busy, enemy_busy, cd_busy}), 64'h0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
